// File: rtl/noaa_pkg.sv
// Shared types and width helpers for the sliding-window temperature statistics engine.
package noaa_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ACCUM = 3'd1,
    SETUP = 3'd2,
    DIV   = 3'd3,
    OUT   = 3'd4
  } state_t;

  localparam logic [11:0] SIGMA_INIT_DEF = 12'h400;

  function automatic int unsigned calc_nw(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

  function automatic int unsigned calc_sum_w(input int unsigned data_w, input int unsigned depth);
    return data_w + calc_nw(depth);
  endfunction

  function automatic int unsigned calc_sq_w(input int unsigned data_w, input int unsigned depth);
    return 2 * data_w + calc_nw(depth);
  endfunction

  function automatic int unsigned calc_qw(input int unsigned data_w);
    return data_w + 1;
  endfunction

endpackage

// File: rtl/noaa_serial_divider.sv
// Restoring divider, one quotient bit per cycle MSB first; quotient saturates to all ones
// when it would not fit in QW bits.
module noaa_serial_divider #(
  parameter int unsigned NUM_W = 34,
  parameter int unsigned DEN_W = 21,
  parameter int unsigned QW    = 13
) (
  input  logic             CLK,
  input  logic             RESET_N,
  input  logic             start,
  input  logic [NUM_W-1:0] num,
  input  logic [DEN_W-1:0] den,
  output logic             done,
  output logic [QW-1:0]    quo
);

  localparam int unsigned RW = (NUM_W > DEN_W + QW) ? NUM_W : DEN_W + QW;
  localparam int unsigned CW = $clog2(QW + 1);

  logic [RW-1:0] rem;
  logic [RW-1:0] dsh;
  logic [CW-1:0] cnt;
  logic          ovf;
  logic          run;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      rem  <= '0;
      dsh  <= '0;
      cnt  <= '0;
      ovf  <= 1'b0;
      run  <= 1'b0;
      done <= 1'b0;
      quo  <= '0;
    end else begin
      done <= 1'b0;
      if (start) begin
        rem <= RW'(num);
        dsh <= RW'(den) << (QW - 1);
        cnt <= CW'(QW);
        ovf <= RW'(num) >= (RW'(den) << QW);
        quo <= '0;
        run <= 1'b1;
      end else if (run) begin
        if (rem >= dsh) begin
          rem <= rem - dsh;
          quo <= {quo[QW-2:0], 1'b1};
        end else begin
          quo <= {quo[QW-2:0], 1'b0};
        end
        dsh <= dsh >> 1;
        cnt <= cnt - CW'(1);
        if (cnt == CW'(1)) begin
          run  <= 1'b0;
          done <= 1'b1;
          if (ovf) quo <= '1;
        end
      end
    end
  end

endmodule

// File: rtl/noaa_window_stats.sv
// Sliding-window average / Newton-refined standard deviation over the last DEPTH samples.
module noaa_window_stats import noaa_pkg::*; #(
  parameter int unsigned          DATA_W     = 12,
  parameter int unsigned          DEPTH      = 14,
  parameter logic [DATA_W-1:0]    SIGMA_INIT = DATA_W'(SIGMA_INIT_DEF),
  localparam int unsigned         NW         = calc_nw(DEPTH)
) (
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic              TN_VALID,
  input  logic [DATA_W-1:0] TN,
  input  logic              MODE,
  output logic              TN_READY,
  input  logic              CLEAR,
  output logic              DONE,
  output logic [DATA_W-1:0] AVG_SD,
  output logic [NW-1:0]     N_OUT,
  output logic [DATA_W-1:0] SIGMA_HAT,
  output logic              BUSY
);

  localparam int unsigned SUM_W = calc_sum_w(DATA_W, DEPTH);
  localparam int unsigned SQ_W  = calc_sq_w(DATA_W, DEPTH);
  localparam int unsigned QW    = calc_qw(DATA_W);
  localparam int unsigned NUM_W = 2 * DATA_W + 2 * NW + 2;
  localparam int unsigned DEN_W = DATA_W + 2 * NW + 1;
  localparam int unsigned PW    = $clog2(DEPTH);

  state_t            state;
  logic [DATA_W-1:0] ring [DEPTH];
  logic [PW-1:0]     wptr;
  logic [NW-1:0]     n;
  logic [SUM_W-1:0]  sum;
  logic [SQ_W-1:0]   sumsq;
  logic [DATA_W-1:0] tn_q;
  logic              mode_q;
  logic [DATA_W-1:0] avg_sd_q;
  logic [DATA_W-1:0] sigma_q;
  logic              done_q;

  logic [DATA_W-1:0] oldest_c;
  logic              full_c;
  logic [SQ_W-1:0]   sq_new_c;
  logic [SQ_W-1:0]   sq_old_c;
  logic [DATA_W-1:0] sh_c;
  logic [NUM_W-1:0]  var_c;
  logic [NUM_W-1:0]  num_c;
  logic [DEN_W-1:0]  den_c;
  logic              div_start_c;
  logic              div_done;
  logic [QW-1:0]     quo;
  logic [QW-1:0]     rnd_c;
  logic [DATA_W-1:0] res_c;

  assign oldest_c    = ring[wptr];
  assign full_c      = (n == NW'(DEPTH));
  assign sq_new_c    = SQ_W'(tn_q) * SQ_W'(tn_q);
  assign sq_old_c    = SQ_W'(oldest_c) * SQ_W'(oldest_c);
  assign sh_c        = (sigma_q == '0) ? DATA_W'(1) : sigma_q;
  assign div_start_c = (state == SETUP);

  // N^2 * variance; the sample set guarantees N*sumsq >= sum^2
  assign var_c = NUM_W'(n) * NUM_W'(sumsq) - NUM_W'(sum) * NUM_W'(sum);

  assign num_c = mode_q
    ? (var_c + NUM_W'(n) * NUM_W'(n) * NUM_W'(sh_c) * NUM_W'(sh_c)) << 1
    : NUM_W'(sum) << 1;
  assign den_c = mode_q
    ? (DEN_W'(n) * DEN_W'(n) * DEN_W'(sh_c)) << 1
    : DEN_W'(n);

  // Quotient carries one extra fractional bit; round half up then clamp
  assign rnd_c = QW'(({1'b0, quo} + (QW + 1)'(1)) >> 1);
  assign res_c = rnd_c[QW-1] ? '1 : rnd_c[DATA_W-1:0];

  noaa_serial_divider #(
    .NUM_W (NUM_W),
    .DEN_W (DEN_W),
    .QW    (QW)
  ) u_div (
    .CLK     (CLK),
    .RESET_N (RESET_N),
    .start   (div_start_c),
    .num     (num_c),
    .den     (den_c),
    .done    (div_done),
    .quo     (quo)
  );

  always_ff @(posedge CLK) begin
    if (state == ACCUM) ring[wptr] <= tn_q;
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state    <= IDLE;
      wptr     <= '0;
      n        <= '0;
      sum      <= '0;
      sumsq    <= '0;
      tn_q     <= '0;
      mode_q   <= 1'b0;
      avg_sd_q <= '0;
      sigma_q  <= SIGMA_INIT;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state)
        IDLE: begin
          if (CLEAR) begin
            n       <= '0;
            sum     <= '0;
            sumsq   <= '0;
            wptr    <= '0;
            sigma_q <= SIGMA_INIT;
          end else if (TN_VALID) begin
            tn_q   <= TN;
            mode_q <= MODE;
            state  <= ACCUM;
          end
        end
        ACCUM: begin
          if (full_c) begin
            sum   <= sum - SUM_W'(oldest_c) + SUM_W'(tn_q);
            sumsq <= sumsq - sq_old_c + sq_new_c;
          end else begin
            n     <= n + NW'(1);
            sum   <= sum + SUM_W'(tn_q);
            sumsq <= sumsq + sq_new_c;
          end
          wptr  <= (wptr == PW'(DEPTH - 1)) ? '0 : wptr + PW'(1);
          state <= SETUP;
        end
        SETUP: state <= DIV;
        DIV: begin
          if (div_done) begin
            avg_sd_q <= res_c;
            done_q   <= 1'b1;
            if (mode_q) sigma_q <= res_c;
            state <= OUT;
          end
        end
        OUT:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign TN_READY  = (state == IDLE) && !CLEAR;
  assign BUSY      = (state != IDLE);
  assign DONE      = done_q;
  assign AVG_SD    = avg_sd_q;
  assign N_OUT     = n;
  assign SIGMA_HAT = sigma_q;

endmodule

// File: tb/tb_noaa_window_stats.sv
// Directed plus randomized bench for noaa_window_stats against a queue-based window model.
module tb_noaa_window_stats;

  localparam int DEPTH = 14;

  logic        CLK;
  logic        RESET_N;
  logic        TN_VALID;
  logic [11:0] TN;
  logic        MODE;
  logic        TN_READY;
  logic        CLEAR;
  logic        DONE;
  logic [11:0] AVG_SD;
  logic [3:0]  N_OUT;
  logic [11:0] SIGMA_HAT;
  logic        BUSY;

  int     n_checks = 0;
  int     n_fail   = 0;
  longint win[$];
  longint sigma_m;

  noaa_window_stats dut (
    .CLK       (CLK),
    .RESET_N   (RESET_N),
    .TN_VALID  (TN_VALID),
    .TN        (TN),
    .MODE      (MODE),
    .TN_READY  (TN_READY),
    .CLEAR     (CLEAR),
    .DONE      (DONE),
    .AVG_SD    (AVG_SD),
    .N_OUT     (N_OUT),
    .SIGMA_HAT (SIGMA_HAT),
    .BUSY      (BUSY)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Window statistics recomputed from scratch over the held samples
  function automatic longint model_result(input logic mode);
    longint s, sq, n, num, den, q, r, sh;
    s = 0;
    sq = 0;
    n = longint'(win.size());
    foreach (win[i]) begin
      s  += win[i];
      sq += win[i] * win[i];
    end
    if (!mode) begin
      num = 2 * s;
      den = n;
    end else begin
      sh  = (sigma_m == 0) ? 1 : sigma_m;
      num = 2 * (n * sq - s * s + n * n * sh * sh);
      den = 2 * n * n * sh;
    end
    q = num / den;
    r = (q + 1) / 2;
    if (r > 4095) r = 4095;
    return r;
  endfunction

  task automatic send(input logic [11:0] tn, input logic mode);
    int     wait_c;
    int     lat;
    bit     rdy_low;
    longint exp_r;
    @(negedge CLK);
    TN = tn;
    MODE = mode;
    TN_VALID = 1'b1;
    wait_c = 0;
    while (!TN_READY && wait_c < 40) begin
      @(negedge CLK);
      wait_c++;
    end
    check("accept_ready", TN_READY, 1);
    @(posedge CLK);
    win.push_back(longint'(tn));
    if (win.size() > DEPTH) void'(win.pop_front());
    exp_r = model_result(mode);
    if (mode) sigma_m = exp_r;
    @(negedge CLK);
    TN_VALID = 1'b0;
    lat = 0;
    rdy_low = 1'b1;
    while (!DONE && lat < 40) begin
      if (TN_READY) rdy_low = 1'b0;
      @(negedge CLK);
      lat++;
    end
    check("done_latency", lat, 16);
    check("ready_low_while_busy", {rdy_low, TN_READY}, 2'b10);
    check("avg_sd", AVG_SD, exp_r);
    check("n_out", N_OUT, win.size());
    check("sigma_hat", SIGMA_HAT, sigma_m);
    @(negedge CLK);
    check("done_pulse_then_ready", {DONE, TN_READY}, 2'b01);
  endtask

  task automatic do_clear();
    @(negedge CLK);
    CLEAR = 1'b1;
    TN_VALID = 1'b1;
    TN = 12'h055;
    #1;
    check("clear_blocks_ready", TN_READY, 0);
    @(negedge CLK);
    CLEAR = 1'b0;
    TN_VALID = 1'b0;
    win.delete();
    sigma_m = 12'h400;
    check("clear_not_accepted", BUSY, 0);
    check("clear_n", N_OUT, 0);
    check("clear_sigma", SIGMA_HAT, 12'h400);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_avg"}, AVG_SD, 0);
    check({tag, "_done"}, DONE, 0);
    check({tag, "_n"}, N_OUT, 0);
    check({tag, "_sigma"}, SIGMA_HAT, 12'h400);
    check({tag, "_ready"}, TN_READY, 1);
    check({tag, "_busy"}, BUSY, 0);
  endtask

  initial begin
    bit seen_done;
    RESET_N = 1'b1;
    TN_VALID = 1'b0;
    TN = '0;
    MODE = 1'b0;
    CLEAR = 1'b0;
    sigma_m = 12'h400;

    // Asynchronous reset, observed before any clock edge
    #2 RESET_N = 1'b0;
    #1;
    check_reset_vals("reset");
    repeat (2) @(negedge CLK);
    RESET_N = 1'b1;

    send(12'd100, 1'b0);
    check("single_avg", AVG_SD, 100);
    check("single_n", N_OUT, 1);

    for (int i = 0; i < 16; i++) send(12'(i), 1'b0);
    check("slide_avg", AVG_SD, 9);
    check("slide_n", N_OUT, 14);

    for (int i = 0; i < 13; i++) send(12'h400, 1'b0);
    send(12'h400, 1'b1);
    check("std_first", AVG_SD, 12'h200);
    check("std_first_sigma", SIGMA_HAT, 12'h200);
    send(12'h400, 1'b1);
    check("std_second", SIGMA_HAT, 12'h100);

    do_clear();
    send(12'd7, 1'b0);
    check("after_clear_avg", AVG_SD, 7);

    for (int i = 0; i < 14; i++) send(12'hFFF, 1'b0);
    check("saturate_avg", AVG_SD, 12'hFFF);

    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 9) == 0) do_clear();
      send(12'($urandom_range(0, 4095)), 1'($urandom_range(0, 1)));
    end

    // Reset while the divider is running must abort without a DONE pulse
    send(12'h010, 1'b0);
    send(12'h020, 1'b1);
    @(negedge CLK);
    TN = 12'h030;
    MODE = 1'b0;
    TN_VALID = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    TN_VALID = 1'b0;
    repeat (6) @(negedge CLK);
    check("abort_busy_before", BUSY, 1);
    #2 RESET_N = 1'b0;
    #1;
    check_reset_vals("abort");
    win.delete();
    sigma_m = 12'h400;
    seen_done = 1'b0;
    repeat (3) @(negedge CLK);
    RESET_N = 1'b1;
    repeat (25) begin
      @(negedge CLK);
      if (DONE) seen_done = 1'b1;
    end
    check("abort_no_done", seen_done, 0);
    send(12'h123, 1'b0);
    check("post_abort_avg", AVG_SD, 12'h123);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
